pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Fetch-stage PC owner. Consumes the decode-stage redirect request (branch, pc_src, jump_address) and holds the architectural fetch PC.
- Applies taken branches and jumps, and drives the IF/ID flush.
- Holds a redirect that arrives during a hazard stall and applies it when the stall releases.
- Keeps a saturating count of applied redirects for performance bring-up.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
COUNT_W, 16, width of the redirect counter.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
stall  input  1  hazard-unit freeze of the PC and IF/ID.
branch  input  1  decode instruction is a branch or jump.
pc_src  input  1  decode redirect is taken; undefined (may be X) when branch=0.
jump_address  input  32  redirect target from decode.
pc  output  32  current fetch PC.
pc_plus_four  output  32  pc + 4, to IF/ID and to decode for link.
if_id_flush  output  1  IF/ID loads a bubble this edge.
fetch_valid  output  1  fetched instruction is valid.
addr_error  output  1  sticky: a misaligned redirect target was seen.
redirect_count  output  COUNT_W  saturating count of applied redirects.

Behaviour:
- Reset (reset_n=0, asynchronous) forces the following at once:
  - pc=RESET_PC, state=RUN, pending_addr=0.
  - fetch_valid=0, addr_error=0, redirect_count=0.
  - if_id_flush=0 (forced low while in reset).
- fetch_valid goes 1 at the first rising edge after reset_n rises and stays 1.
- take = branch & pc_src. When branch=0, pc_src is ignored, so X on pc_src never propagates.
- target = {jump_address[31:2], 2'b00}. Any taken target with jump_address[1:0]!=0 sets addr_error at that edge; it clears only on reset.
- pc_plus_four = pc + 4, combinational, modulo 2^32: 32'hFFFF_FFFC gives 0.
- State RUN:
  - stall=1, take=0: pc holds.
  - stall=1, take=1: pending_addr <= target, go to HOLD; pc holds.
  - stall=0, take=1: pc <= target; if_id_flush=1 this cycle (combinational); redirect_count increments.
  - stall=0, take=0: pc <= pc+4.
- State HOLD:
  - stall=1: pc holds. If take=1, pending_addr <= target (latest decode request wins). take=0 leaves pending_addr unchanged.
  - stall=0: pc <= pending_addr; if_id_flush=1; redirect_count increments; go to RUN. The decode instruction is the same one that was stalled, so the current take is not re-applied.
- if_id_flush is never asserted while stall=1.
- Redirect latency: PC equals target one edge after the unstalled redirect cycle.
- redirect_count saturates at all-ones and does not wrap.
- Reset in HOLD discards pending_addr with no flush.
- The PC update is registered. if_id_flush and pc_plus_four are combinational from state, pc and inputs.

Test Plan:
- Reset release, no branches, stall=0 for 4 cycles → pc goes 0x00400000, 04, 08, 0C; fetch_valid=1 from the first edge; if_id_flush=0 throughout.
- branch=1, pc_src=1, jump_address=0x00400100, stall=0 at pc=0x00400008 → if_id_flush=1 that cycle; pc=0x00400100 next; redirect_count=1.
- branch=0, pc_src=X, stall=0 → pc increments by 4; no flush; no X on any output.
- stall=1 with take to 0x00400200 for 3 cycles, then stall=0 → pc frozen and no flush during the stall; flush in the release cycle; pc=0x00400200 next; count increments once.
- Taken jump_address=0x00400102 → pc=0x00400100; addr_error=1 and stays 1 until reset_n=0.
- reset_n pulsed low mid-HOLD → pc=0x00400000 immediately; pending discarded; count=0; no flush after release.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Decode/hazard side of the fetch PC owner: redirect request, stall, and the
// PC-related status that flows back to IF/ID and decode.
interface pc_redirect_unit_if #(
    parameter int COUNT_W = 16
);
    logic               stall;
    logic               branch;
    logic               pc_src;
    logic [31:0]        jump_address;
    logic [31:0]        pc;
    logic [31:0]        pc_plus_four;
    logic               if_id_flush;
    logic               fetch_valid;
    logic               addr_error;
    logic [COUNT_W-1:0] redirect_count;

    modport master (
        output stall, branch, pc_src, jump_address,
        input  pc, pc_plus_four, if_id_flush, fetch_valid, addr_error, redirect_count
    );

    modport slave (
        input  stall, branch, pc_src, jump_address,
        output pc, pc_plus_four, if_id_flush, fetch_valid, addr_error, redirect_count
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC owner: applies taken branches/jumps, flushes IF/ID on a
// redirect, defers a redirect that arrives under stall until the stall lifts,
// and keeps a saturating count of applied redirects.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal sequencing; a redirect is applied directly when unstalled
// HOLD  | a redirect arrived under stall; pending_addr applied on release
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    pc_redirect_unit_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pending_q, pending_d;
    logic               fetch_valid_q;
    logic               addr_error_q, addr_error_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               flush;

    logic               take;
    logic [31:0]        target;
    logic               misaligned;

    // Gating by branch keeps an undefined pc_src from reaching any state.
    assign take       = bus.branch & (bus.branch ? bus.pc_src : 1'b0);
    assign target     = {bus.jump_address[31:2], 2'b00};
    assign misaligned = bus.jump_address[1:0] != 2'b00;

    // Next-state, PC selection and IF/ID flush decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        addr_error_d = addr_error_q;
        count_d      = count_q;
        flush        = 1'b0;

        if (take && misaligned) begin
            addr_error_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (bus.stall) begin
                    if (take) begin
                        pending_d = target;
                        state_d   = HOLD;
                    end
                end else if (take) begin
                    pc_d  = target;
                    flush = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HOLD: begin
                if (bus.stall) begin
                    if (take) begin
                        pending_d = target;
                    end
                end else begin
                    // The decode instruction is the one that was stalled, so
                    // its take is already captured in pending_q.
                    pc_d    = pending_q;
                    flush   = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (flush && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // State, PC and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pending_q     <= 32'd0;
            fetch_valid_q <= 1'b0;
            addr_error_q  <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            fetch_valid_q <= 1'b1;
            addr_error_q  <= addr_error_d;
            count_q       <= count_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus_four   = pc_q + 32'd4;
    assign bus.if_id_flush    = flush & reset_n;
    assign bus.fetch_valid    = fetch_valid_q;
    assign bus.addr_error     = addr_error_q;
    assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for the fetch PC owner with hand-computed expectations.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          COUNT_W  = 16;

    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    pc_redirect_unit_if #(.COUNT_W(COUNT_W)) bus ();

    pc_redirect_unit #(
        .RESET_PC (RESET_PC),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic src, input logic [31:0] addr);
        bus.stall        = st;
        bus.branch       = br;
        bus.pc_src       = src;
        bus.jump_address = addr;
    endtask

    // Advance one edge and settle past it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        #12;
        chk("rst_pc",    bus.pc, RESET_PC);
        chk("rst_fv",    {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst_flush", {31'd0, bus.if_id_flush}, 32'd0);
        chk("rst_cnt",   {16'd0, bus.redirect_count}, 32'd0);
        chk("rst_aerr",  {31'd0, bus.addr_error}, 32'd0);

        // Release between edges, then sequential fetch.
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("seq_pc0", bus.pc, 32'h0040_0000);
        chk("seq_ppf0", bus.pc_plus_four, 32'h0040_0004);
        cyc();
        chk("seq_pc1", bus.pc, 32'h0040_0004);
        chk("seq_fv1", {31'd0, bus.fetch_valid}, 32'd1);
        chk("seq_fl1", {31'd0, bus.if_id_flush}, 32'd0);
        cyc();
        chk("seq_pc2", bus.pc, 32'h0040_0008);

        // Unstalled taken branch at pc 0x00400008.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0100);
        #1;
        chk("br_flush", {31'd0, bus.if_id_flush}, 32'd1);
        cyc();
        chk("br_pc",  bus.pc, 32'h0040_0100);
        chk("br_cnt", {16'd0, bus.redirect_count}, 32'd1);

        // branch=0 ignores pc_src, whatever it holds.
        drive(1'b0, 1'b0, 1'b1, 32'h0040_0800);
        #1;
        chk("nb_flush", {31'd0, bus.if_id_flush}, 32'd0);
        cyc();
        chk("nb_pc", bus.pc, 32'h0040_0104);
        drive(1'b0, 1'b0, 1'bx, 32'h0040_0800);
        #1;
        chk("nbx_flush", {31'd0, bus.if_id_flush}, 32'd0);
        cyc();
        chk("nbx_pc", bus.pc, 32'h0040_0108);
        chk("nbx_cnt", {16'd0, bus.redirect_count}, 32'd1);

        // Redirect under a 3-cycle stall, applied on release.
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0200);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_flush", {31'd0, bus.if_id_flush}, 32'd0);
            cyc();
            chk("st_pc", bus.pc, 32'h0040_0108);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("rel_flush", {31'd0, bus.if_id_flush}, 32'd1);
        cyc();
        chk("rel_pc",  bus.pc, 32'h0040_0200);
        chk("rel_cnt", {16'd0, bus.redirect_count}, 32'd2);
        chk("rel_fl2", {31'd0, bus.if_id_flush}, 32'd0);

        // Misaligned target: aligned PC, sticky error.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0102);
        cyc();
        chk("mis_pc",   bus.pc, 32'h0040_0100);
        chk("mis_aerr", {31'd0, bus.addr_error}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        cyc();
        cyc();
        chk("mis_pc2",   bus.pc, 32'h0040_0108);
        chk("mis_aerr2", {31'd0, bus.addr_error}, 32'd1);
        chk("mis_cnt",   {16'd0, bus.redirect_count}, 32'd3);

        // HOLD: latest request wins; take on the release cycle is not reapplied.
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0300);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0400);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0040_0700);
        cyc();
        chk("hold_pc", bus.pc, 32'h0040_0108);
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0500);
        #1;
        chk("hold_flush", {31'd0, bus.if_id_flush}, 32'd1);
        cyc();
        chk("hold_pc2", bus.pc, 32'h0040_0400);
        chk("hold_cnt", {16'd0, bus.redirect_count}, 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        cyc();
        chk("hold_pc3", bus.pc, 32'h0040_0404);

        // pc_plus_four wraps at the top of the address space.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc",  bus.pc, 32'hFFFF_FFFC);
        chk("wrap_ppf", bus.pc_plus_four, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        cyc();
        chk("wrap_pc2", bus.pc, 32'h0000_0000);
        chk("wrap_cnt", {16'd0, bus.redirect_count}, 32'd5);

        // Saturation: 65530 more redirects reach all-ones, then one extra.
        drive(1'b0, 1'b1, 1'b1, 32'h0040_0000);
        for (int i = 0; i < 65530; i++) begin
            cyc();
        end
        chk("sat_cnt", {16'd0, bus.redirect_count}, 32'h0000_FFFF);
        cyc();
        chk("sat_cnt2", {16'd0, bus.redirect_count}, 32'h0000_FFFF);

        // Reset while in HOLD discards the pending redirect.
        drive(1'b1, 1'b1, 1'b1, 32'h0040_0600);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("hrst_pc",    bus.pc, RESET_PC);
        chk("hrst_cnt",   {16'd0, bus.redirect_count}, 32'd0);
        chk("hrst_flush", {31'd0, bus.if_id_flush}, 32'd0);
        chk("hrst_aerr",  {31'd0, bus.addr_error}, 32'd0);
        chk("hrst_fv",    {31'd0, bus.fetch_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("hrel_flush", {31'd0, bus.if_id_flush}, 32'd0);
        cyc();
        chk("hrel_pc",    bus.pc, 32'h0040_0004);
        chk("hrel_cnt",   {16'd0, bus.redirect_count}, 32'd0);
        chk("hrel_flush2", {31'd0, bus.if_id_flush}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
